// File: rtl/booth_pkg.sv
// Shared types and saturation limits for the Booth product accumulator.
package booth_pkg;

   localparam int PROD_W = 8;

   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_WAIT  = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Sign-extending saturating adder: acc + sext(prod), clamped to ACC_W bits.
module booth_sat_add
   import booth_pkg::*;
#(
   parameter int ACC_W = 12
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [PROD_W-1:0] b,
   output logic [ACC_W-1:0]  y,
   output logic              ovf
);

   localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(sat_max(ACC_W));
   localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(sat_min(ACC_W));

   logic signed [ACC_W:0] a_x;
   logic signed [ACC_W:0] b_x;
   logic signed [ACC_W:0] full;

   // One guard bit is enough: an 8-bit addend cannot carry past it.
   always_comb begin
      a_x  = $signed({a[ACC_W-1], a});
      b_x  = $signed({{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b});
      full = a_x + b_x;
      y    = full[ACC_W-1:0];
      ovf  = 1'b0;
      if (full > HI) begin
         y   = HI[ACC_W-1:0];
         ovf = 1'b1;
      end else if (full < LO) begin
         y   = LO[ACC_W-1:0];
         ovf = 1'b1;
      end
   end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates TERMS signed Booth products per frame into a saturating sum
// and presents it on a valid/ready handshake.
module booth_product_accumulator
   import booth_pkg::*;
#(
   parameter int ACC_W = 12,
   parameter int TERMS = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Prod_valid,
   input  logic [7:0]       Prod,
   input  logic             Clear,
   input  logic             Sum_ready,
   output logic [ACC_W-1:0] Sum,
   output logic             Sum_valid,
   output logic             Sat,
   output logic             Mul_start,
   output logic             Busy
);

   localparam logic [3:0] LAST = 4'(TERMS - 1);

   state_t           state;
   state_t           state_n;
   logic [ACC_W-1:0] acc;
   logic [3:0]       cnt;
   logic             pv_q;
   logic             start_q;
   logic             rise;
   logic             last;
   logic [ACC_W-1:0] add_y;
   logic             add_ovf;

   booth_sat_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .a   (acc),
      .b   (Prod),
      .y   (add_y),
      .ovf (add_ovf)
   );

   assign rise      = Prod_valid & ~pv_q;
   assign last      = (cnt == LAST);
   assign Mul_start = start_q;
   assign Busy      = (state == S_WAIT) || (state == S_OUT);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= S_START;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_START: state_n = S_WAIT;
         S_WAIT: begin
            if (rise) begin
               state_n = last ? S_OUT : S_START;
            end
         end
         S_OUT: begin
            if (Sum_ready) begin
               state_n = S_START;
            end
         end
         default: state_n = S_START;
      endcase
      if (Clear) begin
         state_n = S_START;
      end
   end

   // Mul_start is the START state delayed one cycle, so it stays low in reset.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         start_q <= 1'b0;
      end else begin
         start_q <= (state == S_START) & ~Clear;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         pv_q      <= 1'b1;
         acc       <= '0;
         cnt       <= '0;
         Sum       <= '0;
         Sum_valid <= 1'b0;
         Sat       <= 1'b0;
      end else begin
         pv_q <= Prod_valid;
         if (Clear) begin
            acc       <= '0;
            cnt       <= '0;
            Sat       <= 1'b0;
            Sum_valid <= 1'b0;
         end else begin
            unique case (state)
               S_WAIT: begin
                  if (rise) begin
                     acc <= add_y;
                     cnt <= cnt + 4'd1;
                     if (add_ovf) begin
                        Sat <= 1'b1;
                     end
                     if (last) begin
                        Sum       <= add_y;
                        Sum_valid <= 1'b1;
                     end
                  end
               end
               S_OUT: begin
                  if (Sum_ready) begin
                     Sum_valid <= 1'b0;
                     acc       <= '0;
                     cnt       <= '0;
                     Sat       <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench: 8-bit and default 12-bit accumulators share one stimulus.
module tb_booth_product_accumulator;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Prod_valid = 1'b1;
   logic [7:0]  Prod = 8'd0;
   logic        Clear = 1'b0;
   logic        Sum_ready = 1'b0;

   logic [7:0]  s8;
   logic        sv8, sat8, ms8, busy8;
   logic [11:0] s12;
   logic        sv12, sat12, ms12, busy12;

   int vectors = 0;
   int errors  = 0;

   always #5 Clk = ~Clk;

   booth_product_accumulator #(.ACC_W(8), .TERMS(4)) u8 (
      .Clk        (Clk),
      .Rst        (Rst),
      .Prod_valid (Prod_valid),
      .Prod       (Prod),
      .Clear      (Clear),
      .Sum_ready  (Sum_ready),
      .Sum        (s8),
      .Sum_valid  (sv8),
      .Sat        (sat8),
      .Mul_start  (ms8),
      .Busy       (busy8)
   );

   booth_product_accumulator u12 (
      .Clk        (Clk),
      .Rst        (Rst),
      .Prod_valid (Prod_valid),
      .Prod       (Prod),
      .Clear      (Clear),
      .Sum_ready  (Sum_ready),
      .Sum        (s12),
      .Sum_valid  (sv12),
      .Sat        (sat12),
      .Mul_start  (ms12),
      .Busy       (busy12)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Multiplier model: drop Valid, then present a new product two negedges later.
   task automatic term(input logic [7:0] p);
      Prod_valid = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      Prod       = p;
      Prod_valid = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_start();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge Clk);
         seen = ms8;
      end
      chk("mul_start_timeout", {31'd0, seen}, 32'd1);
   endtask

   task automatic frame(input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic [7:0] p3);
      term(p0);
      wait_start();
      term(p1);
      wait_start();
      term(p2);
      wait_start();
      term(p3);
   endtask

   task automatic check_out(input string tag, input logic [7:0] e8,
                            input logic e_sat8, input logic [11:0] e12,
                            input logic e_sat12);
      chk({tag, "_sv8"},   {31'd0, sv8},    32'd1);
      chk({tag, "_sum8"},  {24'd0, s8},     {24'd0, e8});
      chk({tag, "_sat8"},  {31'd0, sat8},   {31'd0, e_sat8});
      chk({tag, "_sv12"},  {31'd0, sv12},   32'd1);
      chk({tag, "_sum12"}, {20'd0, s12},    {20'd0, e12});
      chk({tag, "_sat12"}, {31'd0, sat12},  {31'd0, e_sat12});
   endtask

   task automatic handshake();
      @(negedge Clk);
      Sum_ready = 1'b1;
      @(posedge Clk);
      #1;
      chk("xfer_sv8",  {31'd0, sv8},  32'd0);
      chk("xfer_sv12", {31'd0, sv12}, 32'd0);
      @(negedge Clk);
      Sum_ready = 1'b0;
   endtask

   initial begin
      // Reset with a stale-high Valid from the multiplier.
      repeat (2) @(negedge Clk);
      chk("rst_sum",   {24'd0, s8},    32'd0);
      chk("rst_sv",    {31'd0, sv8},   32'd0);
      chk("rst_sat",   {31'd0, sat8},  32'd0);
      chk("rst_ms",    {31'd0, ms8},   32'd0);
      chk("rst_busy",  {31'd0, busy8}, 32'd0);
      Rst = 1'b0;
      @(posedge Clk);
      #1;
      chk("exit_ms",   {31'd0, ms8},   32'd1);
      chk("exit_busy", {31'd0, busy8}, 32'd1);
      @(posedge Clk);
      #1;
      chk("exit_ms_once", {31'd0, ms8},   32'd0);
      chk("exit_wait",    {31'd0, busy8}, 32'd1);

      // Frame 1: 6 - 8 + 64 - 56 = 6; first term checks Mul_start timing.
      term(8'd6);
      chk("acc1_ms_lo", {31'd0, ms8}, 32'd0);
      @(posedge Clk);
      #1;
      chk("acc1_ms_hi", {31'd0, ms8}, 32'd1);
      term(8'hF8);
      wait_start();
      term(8'd64);
      wait_start();
      term(8'hC8);
      check_out("f1", 8'd6, 1'b0, 12'd6, 1'b0);

      // Stall in OUT while Valid keeps toggling.
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         Prod_valid = ~Prod_valid;
         @(posedge Clk);
         #1;
         chk("hold_sum", {24'd0, s8},    32'd6);
         chk("hold_sv",  {31'd0, sv8},   32'd1);
         chk("hold_ms",  {31'd0, ms8},   32'd0);
      end
      @(negedge Clk);
      Sum_ready = 1'b1;
      @(posedge Clk);
      #1;
      chk("rel_sv", {31'd0, sv8}, 32'd0);
      chk("rel_ms", {31'd0, ms8}, 32'd0);
      @(negedge Clk);
      Sum_ready = 1'b0;
      @(posedge Clk);
      #1;
      chk("rel_ms_next", {31'd0, ms8}, 32'd1);

      // Positive saturation on 8 bits; 12 bits holds 256.
      frame(8'd64, 8'd64, 8'd64, 8'd64);
      check_out("fpos", 8'd127, 1'b1, 12'h100, 1'b0);
      handshake();
      wait_start();

      // Negative saturation: -224 fits 12 bits, clamps to -128 on 8.
      frame(8'hC8, 8'hC8, 8'hC8, 8'hC8);
      check_out("fneg", 8'h80, 1'b1, 12'hF20, 1'b0);
      handshake();
      wait_start();

      // Sat must not leak into the next frame.
      frame(8'd1, 8'd1, 8'd1, 8'd1);
      check_out("fone", 8'd4, 1'b0, 12'd4, 1'b0);
      handshake();
      wait_start();

      // Clear coincident with the third rise discards the partial frame.
      term(8'd5);
      wait_start();
      term(8'd5);
      wait_start();
      Prod_valid = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      Prod       = 8'd9;
      Prod_valid = 1'b1;
      Clear      = 1'b1;
      @(posedge Clk);
      #1;
      chk("clr_busy", {31'd0, busy8}, 32'd0);
      chk("clr_sv",   {31'd0, sv8},   32'd0);
      @(negedge Clk);
      Clear = 1'b0;
      wait_start();
      frame(8'd1, 8'd2, 8'd3, 8'd4);
      check_out("fclr", 8'd10, 1'b0, 12'd10, 1'b0);

      // Asynchronous reset while presenting a sum.
      @(negedge Clk);
      #2;
      Rst = 1'b1;
      #1;
      chk("arst_sv8",   {31'd0, sv8},   32'd0);
      chk("arst_sum8",  {24'd0, s8},    32'd0);
      chk("arst_sum12", {20'd0, s12},   32'd0);
      chk("arst_busy",  {31'd0, busy8}, 32'd0);
      @(negedge Clk);
      Rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
